// File: rtl/idma_sync_256b_pkg.sv
// Shared definitions for the iDMA 256-bit sync channel: FSM encoding, beat geometry
// and the bytes-to-beats helper.
package idma_sync_256b_pkg;

  localparam int unsigned BEAT_BYTES = 32;
  localparam int unsigned BEAT_LOG2  = 5;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_WAIT_B = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Number of 32-byte beats covering a byte count; a partial tail costs a full beat.
  function automatic logic [31:0] ceil_beats(input logic [31:0] bytes);
    return (bytes / BEAT_BYTES) + {31'd0, |bytes[BEAT_LOG2-1:0]};
  endfunction

endpackage

// File: rtl/idma_sync_256b_wr_cmd_gen_if.sv
// Descriptor, source-data and write-channel signal bundle of the write command generator.
interface idma_sync_256b_wr_cmd_gen_if #(
  parameter int AXI_DATA_WID = 256,
  parameter int AXI_ADDR_WID = 32,
  parameter int AXI_STRBW    = 32,
  parameter int ROW_NUM_WID  = 16,
  parameter int ROW_BYTE_WID = 20
);

  // A transfer happens on a rising clock edge where the producer's valid and the
  // consumer's ready are both high; valid never waits on ready. wr_req is the one
  // exception: it is a push that already includes wr_addr_ready.
  logic                    desc_valid;
  logic                    desc_ready;
  logic [AXI_ADDR_WID-1:0] desc_base;
  logic [ROW_BYTE_WID-1:0] desc_row_bytes;
  logic [ROW_NUM_WID-1:0]  desc_row_num;
  logic [AXI_ADDR_WID-1:0] desc_stride;

  logic                    src_valid;
  logic [AXI_DATA_WID-1:0] src_data;
  logic                    src_ready;

  logic                    wr_req;
  logic [AXI_ADDR_WID-1:0] wr_addr;
  logic [31:0]             wr_num;
  logic                    wr_addr_ready;

  logic                    wr_data_valid;
  logic [AXI_DATA_WID-1:0] wr_data;
  logic [AXI_STRBW-1:0]    wr_strb;
  logic                    wr_data_ready;

  modport master (
    input  desc_valid, desc_base, desc_row_bytes, desc_row_num, desc_stride,
    output desc_ready,
    input  src_valid, src_data,
    output src_ready,
    output wr_req, wr_addr, wr_num,
    input  wr_addr_ready,
    output wr_data_valid, wr_data, wr_strb,
    input  wr_data_ready
  );

  modport slave (
    output desc_valid, desc_base, desc_row_bytes, desc_row_num, desc_stride,
    input  desc_ready,
    output src_valid, src_data,
    input  src_ready,
    input  wr_req, wr_addr, wr_num,
    output wr_addr_ready,
    input  wr_data_valid, wr_data, wr_strb,
    output wr_data_ready
  );

endinterface

// File: rtl/idma_sync_256b_strb_gen.sv
// Active-low byte mask for a beat: only the last beat of a row with a partial tail
// masks off the bytes at and above the tail offset.
module idma_sync_256b_strb_gen #(
  parameter int STRBW    = 32,
  parameter int TAIL_WID = 5
) (
  input  logic [TAIL_WID-1:0] tail,
  input  logic                last,
  output logic [STRBW-1:0]    strb
);

  always_comb begin
    strb = '0;
    if (last && (tail != '0)) begin
      for (int i = 0; i < STRBW; i++) begin
        strb[i] = (i >= int'(tail));
      end
    end
  end

endmodule

// File: rtl/idma_sync_256b_wr_cmd_gen.sv
// Write-side front end: splits a 2D descriptor into per-row address commands and gates
// the source stream with tail strobes. Define IDMA_WR_CMD_WAIT_BRESP_EN to hold completion
// until write_all_done.
module idma_sync_256b_wr_cmd_gen
  import idma_sync_256b_pkg::*;
#(
  parameter int AXI_DATA_WID = 256,
  parameter int AXI_ADDR_WID = 32,
  parameter int AXI_STRBW    = 32,
  parameter int ROW_NUM_WID  = 16,
  parameter int ROW_BYTE_WID = 20
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cfg_init,
  input  logic                         write_all_done,
  idma_sync_256b_wr_cmd_gen_if.master  bus,
  output logic                         desc_done,
  output logic                         busy,
  output logic [1:0]                   state_dbg
);

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic [AXI_ADDR_WID-1:0] row_addr;
  logic [AXI_ADDR_WID-1:0] stride_q;
  logic [ROW_NUM_WID-1:0]  row_num_q;
  logic [ROW_NUM_WID-1:0]  rows_issued;
  logic [ROW_NUM_WID-1:0]  rows_data;
  logic [ROW_NUM_WID-1:0]  issued_nxt;
  logic [ROW_NUM_WID-1:0]  data_nxt;
  logic [31:0]             wr_num_q;
  logic [31:0]             beat_cnt;
  logic [BEAT_LOG2-1:0]    tail_q;
  logic [ROW_BYTE_WID-1:0] row_bytes_in;
  logic [AXI_DATA_WID-1:0] beat_data;

  logic in_busy;
  logic accept;
  logic desc_zero;
  logic addr_left;
  logic data_left;
  logic beat_fire;
  logic row_last_beat;
  logic row_done;
  logic finish;

`ifndef IDMA_WR_CMD_WAIT_BRESP_EN
  logic unused_write_all_done;
  assign unused_write_all_done = write_all_done;
`endif

  assign row_bytes_in = bus.desc_row_bytes;
  assign in_busy      = (state == ST_BUSY);

  // cfg_init wins over a same-cycle descriptor, so the handshake is withheld then.
  assign bus.desc_ready = (state == ST_IDLE) && !cfg_init;
  assign accept         = bus.desc_valid && bus.desc_ready;
  assign desc_zero      = (row_bytes_in == '0) || (bus.desc_row_num == '0);

  assign addr_left = (rows_issued != row_num_q);
  assign data_left = (rows_data != row_num_q);

  // The address FIFO pushes on wr_req without a full check, so ready is folded in here.
  assign bus.wr_req  = in_busy && addr_left && bus.wr_addr_ready;
  assign bus.wr_addr = row_addr;
  assign bus.wr_num  = wr_num_q;

  assign beat_data         = bus.src_data;
  assign bus.wr_data       = beat_data;
  assign bus.wr_data_valid = in_busy && data_left && bus.src_valid;
  assign bus.src_ready     = in_busy && data_left && bus.wr_data_ready;

  assign beat_fire     = bus.wr_data_valid && bus.wr_data_ready;
  assign row_last_beat = (beat_cnt == (wr_num_q - 32'd1));
  assign row_done      = beat_fire && row_last_beat;

  // Completion looks at post-update counts so a final beat and final request can share a cycle.
  assign issued_nxt = rows_issued + ROW_NUM_WID'(bus.wr_req);
  assign data_nxt   = rows_data + ROW_NUM_WID'(row_done);
  assign finish     = in_busy && (issued_nxt == row_num_q) && (data_nxt == row_num_q);

  idma_sync_256b_strb_gen #(
    .STRBW    (AXI_STRBW),
    .TAIL_WID (BEAT_LOG2)
  ) u_strb_gen (
    .tail (tail_q),
    .last (in_busy && data_left && row_last_beat),
    .strb (bus.wr_strb)
  );

  always_comb begin
    state_nxt = state;
    if (cfg_init) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) state_nxt = desc_zero ? ST_DONE : ST_BUSY;
        end
        ST_BUSY: begin
`ifdef IDMA_WR_CMD_WAIT_BRESP_EN
          if (finish) state_nxt = ST_WAIT_B;
`else
          if (finish) state_nxt = ST_DONE;
`endif
        end
        ST_WAIT_B: begin
`ifdef IDMA_WR_CMD_WAIT_BRESP_EN
          if (write_all_done) state_nxt = ST_DONE;
`else
          state_nxt = ST_IDLE;
`endif
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      row_addr    <= '0;
      stride_q    <= '0;
      row_num_q   <= '0;
      wr_num_q    <= '0;
      tail_q      <= '0;
      rows_issued <= '0;
      rows_data   <= '0;
      beat_cnt    <= '0;
    end else if (cfg_init) begin
      rows_issued <= '0;
      rows_data   <= '0;
      beat_cnt    <= '0;
    end else if (accept) begin
      row_addr    <= bus.desc_base;
      stride_q    <= bus.desc_stride;
      row_num_q   <= bus.desc_row_num;
      wr_num_q    <= ceil_beats(32'(row_bytes_in));
      tail_q      <= row_bytes_in[BEAT_LOG2-1:0];
      rows_issued <= '0;
      rows_data   <= '0;
      beat_cnt    <= '0;
    end else begin
      if (bus.wr_req) begin
        row_addr    <= row_addr + stride_q;
        rows_issued <= issued_nxt;
      end
      if (beat_fire) begin
        if (row_last_beat) begin
          beat_cnt  <= '0;
          rows_data <= data_nxt;
        end else begin
          beat_cnt <= beat_cnt + 32'd1;
        end
      end
    end
  end

  assign desc_done = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_idma_sync_256b_wr_cmd_gen.sv
// Directed bench for idma_sync_256b_wr_cmd_gen: descriptor-level model with a per-cycle
// compare process plus literal checks per scenario.
module tb_idma_sync_256b_wr_cmd_gen;
  import idma_sync_256b_pkg::*;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       cfg_init = 1'b0;
  logic       write_all_done = 1'b1;
  logic       desc_done;
  logic       busy;
  logic [1:0] state_dbg;

  idma_sync_256b_wr_cmd_gen_if bus ();

  idma_sync_256b_wr_cmd_gen dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .cfg_init       (cfg_init),
    .write_all_done (write_all_done),
    .bus            (bus),
    .desc_done      (desc_done),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]  exp_req_q[$];
  logic [287:0] exp_dat_q[$];
  logic [255:0] pend_q[$];
  logic [255:0] src_q[$];
  int           exp_done = 0;

  logic [63:0] req_log[$];
  logic [31:0] strb_log[$];
  int req_cnt, beat_cnt_tb, done_cnt, src_ready_seen;
  int acc_cyc, first_req_cyc, last_req_cyc, last_beat_cyc, done_cyc;
  logic rdy_at_done, rdy_after_done;
  logic src_fire_q = 1'b0;

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic xfer;
    logic src_fire;
    forever begin
      @(negedge aclk);
      src_fire   = bus.src_valid & bus.src_ready;
      src_fire_q = src_fire;
      if (aresetn) begin
        xfer = bus.wr_data_valid & bus.wr_data_ready;
        if (bus.desc_valid && bus.desc_ready) acc_cyc = cyc;
        if (bus.src_ready) src_ready_seen++;
        if (!busy) chk("quiet_outside_busy", {bus.wr_req, bus.wr_data_valid, bus.src_ready}, 3'b000);
        if (bus.wr_req) begin
          req_cnt++;
          last_req_cyc = cyc;
          if (first_req_cyc < 0) first_req_cyc = cyc;
          req_log.push_back({bus.wr_addr, bus.wr_num});
          if (exp_req_q.size() == 0) flag_fail("wr_req_unexpected");
          else chk("wr_req_addr_num", {bus.wr_addr, bus.wr_num}, exp_req_q.pop_front());
        end
        if (xfer || src_fire) chk("src_accept_vs_push", src_fire, xfer);
        if (xfer) begin
          beat_cnt_tb++;
          last_beat_cyc = cyc;
          strb_log.push_back(bus.wr_strb);
          if (exp_dat_q.size() == 0) flag_fail("wr_data_unexpected");
          else chk("wr_data_strb", {bus.wr_data, bus.wr_strb}, exp_dat_q.pop_front());
        end
        if (desc_done) begin
          done_cnt++;
          done_cyc    = cyc;
          rdy_at_done = bus.desc_ready;
          chk("desc_done_expected", exp_done > 0, 1'b1);
          if (exp_done > 0) exp_done--;
          chk("reqs_drained_at_done", exp_req_q.size(), 0);
          chk("data_drained_at_done", exp_dat_q.size(), 0);
        end
        if (cyc == done_cyc + 1) rdy_after_done = bus.desc_ready;
      end
    end
  end

  // ---------------- source feeder ----------------
  initial begin
    bus.src_valid = 1'b0;
    bus.src_data  = '0;
    forever begin
      @(posedge aclk);
      if (src_fire_q && src_q.size() > 0) void'(src_q.pop_front());
      #2;
      bus.src_valid = (src_q.size() != 0);
      bus.src_data  = (src_q.size() != 0) ? src_q[0] : '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      if (pend_q.size() > 0) src_q.push_back(pend_q.pop_front());
    end
  endtask

  task automatic clear_logs();
    req_log.delete();
    strb_log.delete();
    req_cnt        = 0;
    beat_cnt_tb    = 0;
    src_ready_seen = 0;
    first_req_cyc  = -1;
    done_cyc       = -100;
  endtask

  // Model: one request per row at base + r*stride, ceil(bytes/32) beats per row, and the
  // final beat masks off every byte position at or beyond the row's remaining byte count.
  task automatic send_desc(input logic [31:0] base, input logic [19:0] bytes,
                           input logic [15:0] num, input logic [31:0] stride, input bit feed_all);
    logic [31:0]  beats;
    logic [31:0]  strb;
    logic [255:0] d;
    int           rem;
    bit           ok;
    beats = (32'(bytes) + 32'd31) / 32'd32;
    if (bytes != 0 && num != 0) begin
      for (int r = 0; r < int'(num); r++) begin
        exp_req_q.push_back({base + 32'(r) * stride, beats});
        for (int b = 0; b < int'(beats); b++) begin
          rem  = int'(bytes) - b * 32;
          strb = (rem >= 32) ? 32'd0 : ~((32'd1 << rem) - 32'd1);
          d    = rand256();
          pend_q.push_back(d);
          exp_dat_q.push_back({d, strb});
        end
      end
    end
    exp_done++;
    if (feed_all) feed(pend_q.size());
    bus.desc_base      = base;
    bus.desc_row_bytes = bytes;
    bus.desc_row_num   = num;
    bus.desc_stride    = stride;
    bus.desc_valid     = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bus.desc_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk);
    #1;
    bus.desc_valid = 1'b0;
    if (!ok) flag_fail("desc_accept_timeout");
  endtask

  task automatic wait_done(input int budget, input string name);
    int start;
    bit got;
    start = done_cnt;
    got   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge aclk);
      #1;
      if (done_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag_fail(name);
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (beat_cnt_tb >= n) begin
        got = 1'b1;
        break;
      end
      wait_cycles(1);
    end
    if (!got) flag_fail(name);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          d0;
    int          rise;
    logic [31:0] strb_or;

    bus.desc_valid     = 1'b0;
    bus.desc_base      = '0;
    bus.desc_row_bytes = '0;
    bus.desc_row_num   = '0;
    bus.desc_stride    = '0;
    bus.wr_addr_ready  = 1'b1;
    bus.wr_data_ready  = 1'b1;
    done_cnt = 0;
    clear_logs();

    repeat (3) @(negedge aclk);
    chk("rst_desc_ready", bus.desc_ready, 1'b1);
    chk("rst_done_busy", {desc_done, busy}, 2'b00);
    chk("rst_req_valid_ready", {bus.wr_req, bus.wr_data_valid, bus.src_ready}, 3'b000);
    chk("rst_wr_strb", bus.wr_strb, 32'd0);
    chk("rst_wr_addr_num", {bus.wr_addr, bus.wr_num}, 64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    wait_cycles(2);

    // two 64-byte rows
    clear_logs();
    send_desc(32'h1000, 20'd64, 16'd2, 32'h100, 1'b1);
    wait_done(50, "t1_done_timeout");
    wait_cycles(2);
    chk("t1_req_count", req_cnt, 2);
    chk("t1_req0", req_log[0], {32'h1000, 32'd2});
    chk("t1_req1", req_log[1], {32'h1100, 32'd2});
    chk("t1_first_req_latency", first_req_cyc, acc_cyc + 1);
    chk("t1_beats", beat_cnt_tb, 4);
    strb_or = '0;
    foreach (strb_log[i]) strb_or |= strb_log[i];
    chk("t1_strb_all_zero", strb_or, 32'd0);
    chk("t1_done_after_last_beat", done_cyc, last_beat_cyc + 1);
    chk("t1_ready_low_at_done", rdy_at_done, 1'b0);
    chk("t1_ready_back", rdy_after_done, 1'b1);

    // single 40-byte row
    clear_logs();
    send_desc(32'h4000, 20'd40, 16'd1, 32'h0, 1'b1);
    wait_done(50, "t2_done_timeout");
    wait_cycles(2);
    chk("t2_wr_num", req_log[0][31:0], 32'd2);
    chk("t2_strb_beat1", strb_log[0], 32'd0);
    chk("t2_strb_beat2", strb_log[1], 32'hFFFF_FF00);

    // address back-pressure: data runs ahead
    clear_logs();
    bus.wr_addr_ready = 1'b0;
    send_desc(32'h2000, 20'd32, 16'd4, 32'h40, 1'b1);
    wait_cycles(10);
    chk("t3_no_req_while_low", req_cnt, 0);
    chk("t3_beats_passed", beat_cnt_tb, 4);
    chk("t3_still_busy", busy, 1'b1);
    bus.wr_addr_ready = 1'b1;
    wait_done(50, "t3_done_timeout");
    wait_cycles(2);
    chk("t3_req_count", req_cnt, 4);
    chk("t3_req3", req_log[3], {32'h20C0, 32'd1});
    chk("t3_done_after_last_req", done_cyc, last_req_cyc + 1);

    // zero-length descriptors
    clear_logs();
    src_q.push_back(rand256());
    src_q.push_back(rand256());
    send_desc(32'h5000, 20'd0, 16'd3, 32'h40, 1'b0);
    wait_done(20, "t4_done_timeout");
    wait_cycles(2);
    chk("t4_done_latency", done_cyc, acc_cyc + 1);
    chk("t4_no_req", req_cnt, 0);
    chk("t4_src_ready_never", src_ready_seen, 0);
    send_desc(32'h5000, 20'd64, 16'd0, 32'h40, 1'b0);
    wait_done(20, "t4b_done_timeout");
    wait_cycles(2);
    chk("t4b_done_latency", done_cyc, acc_cyc + 1);
    chk("t4b_no_traffic", {req_cnt, src_ready_seen}, 64'd0);
    src_q.delete();
    wait_cycles(2);

    // cfg_init mid-row, then restart
    clear_logs();
    send_desc(32'h6000, 20'd256, 16'd1, 32'h0, 1'b0);
    feed(3);
    wait_beats(3, 30, "t5_beats_timeout");
    d0 = done_cnt;
    cfg_init = 1'b1;
    @(posedge aclk);
    #1;
    cfg_init = 1'b0;
    exp_req_q.delete();
    exp_dat_q.delete();
    pend_q.delete();
    exp_done = 0;
    @(negedge aclk);
    chk("t5_ready_after_init", bus.desc_ready, 1'b1);
    chk("t5_idle_after_init", {busy, state_dbg}, {1'b0, ST_IDLE});
    wait_cycles(10);
    chk("t5_no_done", done_cnt, d0);
    clear_logs();
    send_desc(32'h3000, 20'd40, 16'd2, 32'h80, 1'b1);
    wait_done(50, "t5_restart_timeout");
    wait_cycles(2);
    chk("t5_req0", req_log[0], {32'h3000, 32'd2});
    chk("t5_req1", req_log[1], {32'h3080, 32'd2});
    chk("t5_strb_row0_tail", strb_log[1], 32'hFFFF_FF00);
    chk("t5_strb_row1_tail", strb_log[3], 32'hFFFF_FF00);

    // completion versus write_all_done
    clear_logs();
    write_all_done = 1'b0;
`ifdef IDMA_WR_CMD_WAIT_BRESP_EN
    send_desc(32'h7000, 20'd64, 16'd1, 32'h0, 1'b1);
    wait_beats(2, 30, "t6_beats_timeout");
    d0 = done_cnt;
    wait_cycles(20);
    chk("t6_held_for_bresp", done_cnt, d0);
    chk("t6_in_wait_b", state_dbg, ST_WAIT_B);
    write_all_done = 1'b1;
    rise = cyc;
    wait_done(20, "t6_done_timeout");
    wait_cycles(2);
    chk("t6_done_after_rise", done_cyc, rise + 1);
`else
    send_desc(32'h7000, 20'd64, 16'd1, 32'h0, 1'b1);
    wait_done(50, "t6_done_timeout");
    wait_cycles(2);
    rise = last_beat_cyc;
    chk("t6_done_ignores_bresp", done_cyc, rise + 1);
    write_all_done = 1'b1;
`endif

    // address wrap with random back-pressure on both channels
    clear_logs();
    send_desc(32'hFFFF_FFE0, 20'd33, 16'd3, 32'h40, 1'b1);
    d0 = done_cnt;
    for (int i = 0; i < 300; i++) begin
      bus.wr_addr_ready = 1'($urandom_range(0, 1));
      bus.wr_data_ready = 1'($urandom_range(0, 1));
      wait_cycles(1);
      if (done_cnt != d0) break;
    end
    bus.wr_addr_ready = 1'b1;
    bus.wr_data_ready = 1'b1;
    if (done_cnt == d0) wait_done(50, "t7_done_timeout");
    wait_cycles(2);
    chk("t7_req_count", req_cnt, 3);
    chk("t7_req1_wrapped", req_log[1], {32'h0000_0020, 32'd2});
    chk("t7_strb_tail1", strb_log[1], 32'hFFFF_FFFE);
    chk("t7_beats", beat_cnt_tb, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "simulation time limit");
  end

endmodule
